param_display_seq: RTL
======================

Name: param_display_seq

Overview:
Clocked successor to the combinational parameter display. It registers the fx/param/value selection and converts the value to decimal with a sequential double-dabble. It drives six seven-segment digits and a ballistic LED bar meter (instant rise, timed fall), blinks the value while editing, and blanks the value readout after an inactivity timeout. It sits between the parameter-edit controller and the board HEX/LEDR pins.

Parameters:
FX_COUNT, 16, number of effects; fx_sel width = $clog2(FX_COUNT), max 16 so fx fits one hex digit
PARAM_COUNT, 8, parameters per effect; param_sel width = $clog2(PARAM_COUNT), max 16
PARAM_W, 7, value width; legal range 1..9 so value fits 3 decimal digits
LED_COUNT, 10, LED bar length; legal range 1..10 (level register 4 bits)
TIMEOUT_CYCLES, 150_000_000, clk cycles without change before readout blanks
BLINK_CYCLES, 12_500_000, half-period of edit blink
STEP_CYCLES, 2_500_000, clk cycles per one-LED fall step

Ports:
clk  in  1  system clock, all state rising-edge
reset  in  1  synchronous, active-high
fx_sel  in  $clog2(FX_COUNT)  selected effect
param_sel  in  $clog2(PARAM_COUNT)  selected parameter
current_value  in  PARAM_W  value being edited
edit_en  in  1  edit mode active
busy  out  1  decimal conversion in progress
LEDR  out  LED_COUNT  bar meter, filled from LEDR[LED_COUNT-1] downward
HEX0..HEX5  out  7 each  segment outputs via sevseg_display (lab_pkg index encoding)

Behaviour:
- Reset (synchronous, any state, including mid-conversion): state CONV_PENDING, busy=0, LEDR=0, HEX0..HEX5 = SEVSEG_BLANK_INDEX, all timers=0, snapshot cleared, force flag=1.
- Snapshot register holds {fx_sel, param_sel, current_value}.
- Change event = inputs differ from snapshot, or force flag set. On a change edge: load snapshot and shift register, clear force flag, clear iteration count, go to CONV.
- States:
  - IDLE: no readout shown.
  - CONV: busy=1; one double-dabble iteration per cycle (add 3 to any BCD nibble >=5, then shift left 1).
  - SHOW: readout displayed.
- A change event in any state (including CONV) restarts conversion with the new snapshot. The previous value is never committed.
- Commit edge: after PARAM_W CONV cycles, the next edge commits digits, fx, param and LED target together, sets busy=0 and enters SHOW.
  - Outputs therefore change PARAM_W+1 edges after the change edge.
  - Display contents do not change during CONV.
- Digit mapping:
  - HEX5 = committed fx.
  - HEX4 = committed param.
  - HEX2/HEX1/HEX0 = hundreds/tens/units.
  - Leading zeros blanked; units always shown (value 0 shows "0").
  - HEX3 = SEVSEG_LINE_INDEX when edit_en=1 in SHOW, else blank.
- Blink: in SHOW with edit_en=1, HEX2..HEX0 are on for BLINK_CYCLES, then blank for BLINK_CYCLES, repeating. Blink counter resets to the on-phase start at every commit and when edit_en rises.
- LED target level:
  - value 0 -> 1.
  - otherwise ceil(value*LED_COUNT / MAX_VAL), clamped to [1, LED_COUNT], where MAX_VAL = 2^PARAM_W - 1.
  - Computed at full width, no overflow.
- Displayed level (SHOW only):
  - target > level: level = target on the commit edge, step counter cleared.
  - target < level: decrement by 1 every STEP_CYCLES edges.
  - target == level: step counter held at 0.
  - LEDR[LED_COUNT-1-i] = 1 for i < level.
- Timeout:
  - Timer clears on commit; increments each SHOW cycle with edit_en=0; held at 0 while edit_en=1.
  - Enter IDLE on the edge where the timer would reach TIMEOUT_CYCLES, i.e. TIMEOUT_CYCLES edges after commit.
  - IDLE: HEX3..HEX0 blank, LEDR=0, level=0; HEX5/HEX4 keep committed fx/param.
  - IDLE -> CONV only on a change event.
- Simultaneous events: reset beats everything; a change event on the timeout edge goes to CONV, not IDLE.

Test Plan:
(Parameters for all scenarios: PARAM_W=7, LED_COUNT=10, TIMEOUT_CYCLES=20, BLINK_CYCLES=4, STEP_CYCLES=3.)
1. Reset release with fx=3, param=5, value=127:
   - busy high 7 cycles.
   - At edge 8: HEX5=3, HEX4=5, HEX2/1/0 = 1/2/7, LEDR=10'h3FF.
2. Value 5, then value 0:
   - value 5 -> HEX2/HEX1 blank, HEX0=5, LEDR=10'h200.
   - value 0 -> HEX0=0, LEDR=10'h200.
   - value 64 -> HEX1/HEX0 = 6/4, LEDR=10'h3F0.
3. Value 100, changed to 42 on the 3rd CONV cycle:
   - 100 never displayed.
   - HEX1/HEX0 = 4/2 exactly 8 edges after the second change.
4. Commit 127, then 0:
   - LEDR falls 10->9 three edges after the second commit, then one LED per 3 edges, reaching 1 (10'h200) after 27 edges.
   - Next change to 127 restores 10'h3FF on its commit edge.
5. Commit with edit_en=0, no change:
   - 20 edges later: HEX3..HEX0 blank, LEDR=0, HEX5/HEX4 retained.
   - Changing value re-enters CONV, then SHOW.
6. edit_en=1:
   - HEX3 = line, digits blink 4 on / 4 off, no timeout after 100 cycles.
   - Reset asserted mid-CONV -> next edge all HEX blank, LEDR=0, busy=0.

Source files
------------

// File: rtl/param_display_seq_if.sv
// param_display_seq_if
// Bundles the signals between the parameter-edit controller and the display
// block, and between the display block and the board pins.
//   fx_sel, param_sel, current_value, edit_en : selection/value from controller
//   busy                                      : decimal conversion in progress
//   LEDR                                      : bar meter, filled from the top bit down
//   HEX0..HEX5                                : seven-segment digits (active-low segments)
// Modports: master = controller/board side, slave = display block.
interface param_display_seq_if #(
    parameter int FX_COUNT    = 16,
    parameter int PARAM_COUNT = 8,
    parameter int PARAM_W     = 7,
    parameter int LED_COUNT   = 10
);
    localparam int FX_W = $clog2(FX_COUNT);
    localparam int PS_W = $clog2(PARAM_COUNT);

    logic [FX_W-1:0]      fx_sel;
    logic [PS_W-1:0]      param_sel;
    logic [PARAM_W-1:0]   current_value;
    logic                 edit_en;
    logic                 busy;
    logic [LED_COUNT-1:0] LEDR;
    logic [6:0]           HEX0;
    logic [6:0]           HEX1;
    logic [6:0]           HEX2;
    logic [6:0]           HEX3;
    logic [6:0]           HEX4;
    logic [6:0]           HEX5;

    modport master (
        output fx_sel, param_sel, current_value, edit_en,
        input  busy, LEDR, HEX0, HEX1, HEX2, HEX3, HEX4, HEX5
    );

    modport slave (
        input  fx_sel, param_sel, current_value, edit_en,
        output busy, LEDR, HEX0, HEX1, HEX2, HEX3, HEX4, HEX5
    );
endinterface

// File: rtl/param_display_seq.sv
// param_display_seq
// Registers the effect/parameter/value selection, converts the value to
// decimal with a one-bit-per-cycle double-dabble, and drives six
// seven-segment digits plus a ballistic LED bar (instant rise, stepped fall).
// The value readout blinks while editing and blanks after an idle timeout.
// Ports:
//   clk   : system clock, all state on the rising edge
//   reset : synchronous, active-high
//   bus   : param_display_seq_if.slave (inputs from controller, HEX/LEDR/busy out)
module param_display_seq #(
    parameter int FX_COUNT       = 16,
    parameter int PARAM_COUNT    = 8,
    parameter int PARAM_W        = 7,
    parameter int LED_COUNT      = 10,
    parameter int TIMEOUT_CYCLES = 150_000_000,
    parameter int BLINK_CYCLES   = 12_500_000,
    parameter int STEP_CYCLES    = 2_500_000
) (
    input  logic               clk,
    input  logic               reset,
    param_display_seq_if.slave bus
);
    localparam int FX_W    = $clog2(FX_COUNT);
    localparam int PS_W    = $clog2(PARAM_COUNT);
    localparam int BCD_W   = 12;
    localparam int SH_W    = BCD_W + PARAM_W;
    localparam int IT_W    = $clog2(PARAM_W + 1);
    localparam int LV_W    = 4;
    localparam int TMO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int BLK_W   = $clog2(2 * BLINK_CYCLES + 1);
    localparam int STP_W   = $clog2(STEP_CYCLES + 1);
    localparam int MAX_VAL = (1 << PARAM_W) - 1;
    localparam int NUM_W   = PARAM_W + 5;

    localparam logic [4:0] SEVSEG_BLANK_INDEX = 5'd16;
    localparam logic [4:0] SEVSEG_LINE_INDEX  = 5'd17;

    typedef enum logic [1:0] {
        ST_CONV_PENDING,
        ST_IDLE,
        ST_CONV,
        ST_SHOW
    } state_t;

    state_t             state_q, state_d;
    logic               force_q, force_d;
    logic [FX_W-1:0]    snap_fx_q, snap_fx_d;
    logic [PS_W-1:0]    snap_param_q, snap_param_d;
    logic [PARAM_W-1:0] snap_val_q, snap_val_d;
    logic [SH_W-1:0]    sh_q, sh_d;
    logic [IT_W-1:0]    iter_q, iter_d;
    logic               shown_q, shown_d;     // fx/param committed at least once
    logic               readout_q, readout_d; // value digits visible
    logic [FX_W-1:0]    fx_q, fx_d;
    logic [PS_W-1:0]    param_q, param_d;
    logic [3:0]         hund_q, hund_d;
    logic [3:0]         tens_q, tens_d;
    logic [3:0]         units_q, units_d;
    logic [LV_W-1:0]    target_q, target_d;
    logic [LV_W-1:0]    level_q, level_d;
    logic [STP_W-1:0]   step_q, step_d;
    logic [BLK_W-1:0]   blink_q, blink_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;

    // ---------------- double-dabble iteration ----------------
    logic [SH_W-1:0] sh_adj;
    logic [SH_W-1:0] sh_iter;

    assign sh_adj[PARAM_W-1:0] = sh_q[PARAM_W-1:0];

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_dd
            logic [3:0] nib;
            assign nib = sh_q[PARAM_W + 4*gi +: 4];
            assign sh_adj[PARAM_W + 4*gi +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
        end
    endgenerate

    assign sh_iter = sh_adj << 1;

    // ---------------- LED target: ceil(v*LED_COUNT/MAX_VAL), clamped ----------------
    logic [NUM_W-1:0] num;
    logic [NUM_W-1:0] quot;
    logic [LV_W-1:0]  target_calc;

    assign num  = NUM_W'(snap_val_q) * NUM_W'(LED_COUNT) + NUM_W'(MAX_VAL - 1);
    assign quot = num / NUM_W'(MAX_VAL);

    always_comb begin
        target_calc = quot[LV_W-1:0];
        if (snap_val_q == '0 || quot == '0) begin
            target_calc = LV_W'(1);
        end else if (quot > NUM_W'(LED_COUNT)) begin
            target_calc = LV_W'(LED_COUNT);
        end
    end

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_CONV_PENDING;
            force_q      <= 1'b1;
            snap_fx_q    <= '0;
            snap_param_q <= '0;
            snap_val_q   <= '0;
            sh_q         <= '0;
            iter_q       <= '0;
            shown_q      <= 1'b0;
            readout_q    <= 1'b0;
            fx_q         <= '0;
            param_q      <= '0;
            hund_q       <= '0;
            tens_q       <= '0;
            units_q      <= '0;
            target_q     <= '0;
            level_q      <= '0;
            step_q       <= '0;
            blink_q      <= '0;
            tmo_q        <= '0;
        end else begin
            state_q      <= state_d;
            force_q      <= force_d;
            snap_fx_q    <= snap_fx_d;
            snap_param_q <= snap_param_d;
            snap_val_q   <= snap_val_d;
            sh_q         <= sh_d;
            iter_q       <= iter_d;
            shown_q      <= shown_d;
            readout_q    <= readout_d;
            fx_q         <= fx_d;
            param_q      <= param_d;
            hund_q       <= hund_d;
            tens_q       <= tens_d;
            units_q      <= units_d;
            target_q     <= target_d;
            level_q      <= level_d;
            step_q       <= step_d;
            blink_q      <= blink_d;
            tmo_q        <= tmo_d;
        end
    end

    // ---------------- next state ----------------
    logic change;

    assign change = force_q
                 || (bus.fx_sel != snap_fx_q)
                 || (bus.param_sel != snap_param_q)
                 || (bus.current_value != snap_val_q);

    always_comb begin
        state_d      = state_q;
        force_d      = force_q;
        snap_fx_d    = snap_fx_q;
        snap_param_d = snap_param_q;
        snap_val_d   = snap_val_q;
        sh_d         = sh_q;
        iter_d       = iter_q;
        shown_d      = shown_q;
        readout_d    = readout_q;
        fx_d         = fx_q;
        param_d      = param_q;
        hund_d       = hund_q;
        tens_d       = tens_q;
        units_d      = units_q;
        target_d     = target_q;
        level_d      = level_q;
        step_d       = step_q;
        blink_d      = blink_q;
        tmo_d        = tmo_q;

        if (change) begin
            // A change always (re)starts conversion; an in-flight value is dropped.
            snap_fx_d    = bus.fx_sel;
            snap_param_d = bus.param_sel;
            snap_val_d   = bus.current_value;
            sh_d         = {{BCD_W{1'b0}}, bus.current_value};
            iter_d       = '0;
            force_d      = 1'b0;
            state_d      = ST_CONV;
        end else begin
            case (state_q)
                ST_CONV: begin
                    if (iter_q != IT_W'(PARAM_W)) begin
                        sh_d   = sh_iter;
                        iter_d = iter_q + 1'b1;
                    end else begin
                        // Commit: every visible field updates on this one edge.
                        fx_d      = snap_fx_q;
                        param_d   = snap_param_q;
                        hund_d    = sh_q[PARAM_W + 8 +: 4];
                        tens_d    = sh_q[PARAM_W + 4 +: 4];
                        units_d   = sh_q[PARAM_W +: 4];
                        target_d  = target_calc;
                        if (target_calc > level_q) begin
                            level_d = target_calc;
                        end
                        step_d    = '0;
                        blink_d   = '0;
                        tmo_d     = '0;
                        shown_d   = 1'b1;
                        readout_d = 1'b1;
                        state_d   = ST_SHOW;
                    end
                end
                ST_SHOW: begin
                    // Ballistic fall: one LED per STEP_CYCLES edges.
                    if (target_q < level_q) begin
                        if (step_q == STP_W'(STEP_CYCLES - 1)) begin
                            level_d = level_q - 1'b1;
                            step_d  = '0;
                        end else begin
                            step_d = step_q + 1'b1;
                        end
                    end else begin
                        step_d = '0;
                    end

                    // Blink phase held at on-start while not editing, so a
                    // rising edit_en always begins with the digits shown.
                    if (bus.edit_en) begin
                        if (blink_q == BLK_W'(2 * BLINK_CYCLES - 1)) begin
                            blink_d = '0;
                        end else begin
                            blink_d = blink_q + 1'b1;
                        end
                    end else begin
                        blink_d = '0;
                    end

                    if (bus.edit_en) begin
                        tmo_d = '0;
                    end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                        tmo_d     = '0;
                        readout_d = 1'b0;
                        level_d   = '0;
                        step_d    = '0;
                        state_d   = ST_IDLE;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
                default: begin
                    // IDLE and CONV_PENDING wait for a change event.
                end
            endcase
        end
    end

    // ---------------- outputs ----------------
    function automatic logic [6:0] seg7(input logic [4:0] idx);
        logic [6:0] s;
        case (idx)
            5'd0:    s = 7'h40;
            5'd1:    s = 7'h79;
            5'd2:    s = 7'h24;
            5'd3:    s = 7'h30;
            5'd4:    s = 7'h19;
            5'd5:    s = 7'h12;
            5'd6:    s = 7'h02;
            5'd7:    s = 7'h78;
            5'd8:    s = 7'h00;
            5'd9:    s = 7'h10;
            5'd10:   s = 7'h08;
            5'd11:   s = 7'h03;
            5'd12:   s = 7'h46;
            5'd13:   s = 7'h21;
            5'd14:   s = 7'h06;
            5'd15:   s = 7'h0E;
            5'd17:   s = 7'h3F;  // middle bar only
            default: s = 7'h7F;  // blank
        endcase
        return s;
    endfunction

    logic       editing_show;
    logic       blink_off;
    logic       digits_on;
    logic [4:0] idx5, idx4, idx3, idx2, idx1, idx0;

    assign editing_show = (state_q == ST_SHOW) && bus.edit_en;
    assign blink_off    = editing_show && (blink_q >= BLK_W'(BLINK_CYCLES));
    assign digits_on    = readout_q && !blink_off;

    assign idx5 = shown_q ? 5'(fx_q) : SEVSEG_BLANK_INDEX;
    assign idx4 = shown_q ? 5'(param_q) : SEVSEG_BLANK_INDEX;
    assign idx3 = editing_show ? SEVSEG_LINE_INDEX : SEVSEG_BLANK_INDEX;
    assign idx2 = (digits_on && hund_q != 4'd0) ? 5'(hund_q) : SEVSEG_BLANK_INDEX;
    assign idx1 = (digits_on && (hund_q != 4'd0 || tens_q != 4'd0)) ? 5'(tens_q) : SEVSEG_BLANK_INDEX;
    assign idx0 = digits_on ? 5'(units_q) : SEVSEG_BLANK_INDEX;

    assign bus.HEX5 = seg7(idx5);
    assign bus.HEX4 = seg7(idx4);
    assign bus.HEX3 = seg7(idx3);
    assign bus.HEX2 = seg7(idx2);
    assign bus.HEX1 = seg7(idx1);
    assign bus.HEX0 = seg7(idx0);
    assign bus.busy = (state_q == ST_CONV);

    generate
        for (genvar gi = 0; gi < LED_COUNT; gi++) begin : g_bar
            assign bus.LEDR[LED_COUNT-1-gi] = (level_q > LV_W'(gi));
        end
    endgenerate
endmodule
